// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the fetch PC, addresses the BIOS/IMEM synchronous-read ports from pc_next
// and presents one instruction per cycle to decode, honouring stall and redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter int          BIOS_AW  = 12,
  parameter int          IMEM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [BIOS_AW-1:0] bios_addr,
  input  logic [31:0]        bios_dout,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_dout,
  output logic [31:0]        inst,
  output logic [31:0]        inst_pc,
  output logic               inst_valid,
  output logic               fetch_fault,
  output logic [31:0]        fetch_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_FAULT
  } state_t;

  function automatic logic pc_is_bad(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || !((pc[31:28] == 4'b0100) || (pc[31:28] == 4'b0001));
  endfunction

  localparam logic LP_RESET_IN_BIOS = (RESET_PC[31:28] == 4'b0100);

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_region_bios;
  logic        r_inst_valid;
  logic        r_fetch_fault;
  logic [31:0] r_count;

  logic [31:0] w_pc_next;
  logic        w_next_bad;
  logic        w_accept;
  state_t      w_state_next;

  // Redirect wins over everything; BOOT/FAULT/stall re-present the current PC so memory output stays put.
  always_comb begin
    w_pc_next = r_pc + 32'd4;
    if (redirect_valid) begin
      w_pc_next = redirect_pc;
    end else if ((r_state != S_RUN) || stall) begin
      w_pc_next = r_pc;
    end
  end

  assign w_next_bad = pc_is_bad(w_pc_next);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_BOOT, S_RUN: w_state_next = w_next_bad ? S_FAULT : S_RUN;
      S_FAULT:       w_state_next = (redirect_valid && !w_next_bad) ? S_RUN : S_FAULT;
      default:       w_state_next = S_BOOT;
    endcase
  end

  // The instruction on display during a redirect is squashed, so it is not counted.
  assign w_accept = r_inst_valid & ~stall & ~redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_PC;
      r_region_bios <= LP_RESET_IN_BIOS;
      r_inst_valid  <= 1'b0;
      r_fetch_fault <= 1'b0;
      r_count       <= 32'd0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_region_bios <= (w_pc_next[31:28] == 4'b0100);
      r_inst_valid  <= (w_state_next == S_RUN);
      r_fetch_fault <= (w_state_next == S_FAULT);
      if (w_accept) begin
        r_count <= r_count + 32'd1;
      end
    end
  end

  assign bios_addr   = w_pc_next[BIOS_AW+1:2];
  assign imem_addr   = w_pc_next[IMEM_AW+1:2];
  assign inst        = r_inst_valid ? (r_region_bios ? bios_dout : imem_dout) : NOP;
  assign inst_pc     = r_pc;
  assign inst_valid  = r_inst_valid;
  assign fetch_fault = r_fetch_fault;
  assign fetch_count = r_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run against a cycle-level model
// that derives each expected instruction straight from the memory contents at the expected PC.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [11:0] bios_addr;
  logic [31:0] bios_dout;
  logic [13:0] imem_addr;
  logic [31:0] imem_dout;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  logic [31:0] bios_mem [0:4095];
  logic [31:0] imem_mem [0:16383];

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode 0 = booting, 1 = running, 2 = faulted
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_count;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .BIOS_AW(12), .IMEM_AW(14)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .bios_addr(bios_addr), .bios_dout(bios_dout),
    .imem_addr(imem_addr), .imem_dout(imem_dout), .inst(inst), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .fetch_fault(fetch_fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bios_dout <= bios_mem[bios_addr];
    imem_dout <= imem_mem[imem_addr];
  end

  function automatic bit pc_good(input logic [31:0] pc);
    bit in_bios, in_imem;
    in_bios = (pc >= 32'h4000_0000) && (pc <= 32'h4FFF_FFFC);
    in_imem = (pc >= 32'h1000_0000) && (pc <= 32'h1FFF_FFFC);
    return (pc % 4 == 0) && (in_bios || in_imem);
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    int unsigned widx;
    widx = pc / 4;
    if (pc >= 32'h4000_0000 && pc <= 32'h4FFF_FFFF) return bios_mem[widx % 4096];
    return imem_mem[widx % 16384];
  endfunction

  function automatic logic [31:0] model_next_pc();
    if (redirect_valid) return redirect_pc;
    if (m_mode != 1 || stall) return m_pc;
    return m_pc + 32'd4;
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_pc    = RESET_PC;
    m_count = 32'd0;
  endtask

  task automatic drive(input logic s, input logic rv, input logic [31:0] rpc);
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic tick();
    logic [31:0] npc;
    npc = model_next_pc();
    if (rst_n) begin
      if (m_mode == 1 && !stall && !redirect_valid) m_count = m_count + 32'd1;
      if (!(m_mode == 2 && !redirect_valid)) m_mode = pc_good(npc) ? 1 : 2;
      m_pc = npc;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    model_reset();
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
    n_tests++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got=%b exp=0", fetch_fault); end
    n_tests++; if (inst !== NOP) begin n_fail++; $display("FAIL reset_inst got=%h exp=%h", inst, NOP); end
    n_tests++; if (inst_pc !== RESET_PC) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", inst_pc, RESET_PC); end
    n_tests++; if (fetch_count !== 32'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_boot();
    // cycle 1: BOOT
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL boot_c1_valid got=%b exp=0", inst_valid); end
    n_tests++; if (bios_addr !== 12'd0) begin n_fail++; $display("FAIL boot_c1_addr got=%h exp=0", bios_addr); end
    tick();
    n_tests++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL boot_c2_valid got=%b exp=1", inst_valid); end
    n_tests++; if (inst !== 32'h1000_02b7) begin n_fail++; $display("FAIL boot_c2_inst got=%h exp=100002b7", inst); end
    n_tests++; if (inst_pc !== 32'h4000_0000) begin n_fail++; $display("FAIL boot_c2_pc got=%h exp=40000000", inst_pc); end
    tick();
    n_tests++; if (inst !== 32'h0002_8067) begin n_fail++; $display("FAIL boot_c3_inst got=%h exp=00028067", inst); end
    n_tests++; if (inst_pc !== 32'h4000_0004) begin n_fail++; $display("FAIL boot_c3_pc got=%h exp=40000004", inst_pc); end
    n_tests++; if (fetch_count !== 32'd1) begin n_fail++; $display("FAIL boot_c3_count got=%0d exp=1", fetch_count); end
  endtask

  task automatic test_jump_imem();
    drive(1'b0, 1'b1, 32'h1000_0000);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    n_tests++; if (inst !== 32'h00a0_0293) begin n_fail++; $display("FAIL jump_inst got=%h exp=00a00293", inst); end
    n_tests++; if (inst_pc !== 32'h1000_0000) begin n_fail++; $display("FAIL jump_pc got=%h exp=10000000", inst_pc); end
    n_tests++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL jump_valid got=%b exp=1", inst_valid); end
    n_tests++; if (fetch_count !== 32'd1) begin n_fail++; $display("FAIL jump_squash_count got=%0d exp=1", fetch_count); end
    tick();
  endtask

  task automatic test_stall();
    logic [31:0] c0;
    c0 = fetch_count;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 32'h0);
      n_tests++; if (inst_pc !== 32'h1000_0004) begin n_fail++; $display("FAIL stall_pc[%0d] got=%h exp=10000004", k, inst_pc); end
      n_tests++; if (inst !== imem_mem[1]) begin n_fail++; $display("FAIL stall_inst[%0d] got=%h exp=%h", k, inst, imem_mem[1]); end
      n_tests++; if (fetch_count !== c0) begin n_fail++; $display("FAIL stall_count[%0d] got=%0d exp=%0d", k, fetch_count, c0); end
      tick();
    end
    drive(1'b0, 1'b0, 32'h0);
    n_tests++; if (inst_pc !== 32'h1000_0004) begin n_fail++; $display("FAIL stall_release_pc got=%h exp=10000004", inst_pc); end
    tick();
    n_tests++; if (inst_pc !== 32'h1000_0008) begin n_fail++; $display("FAIL stall_after_pc got=%h exp=10000008", inst_pc); end
    n_tests++; if (fetch_count !== c0 + 32'd1) begin n_fail++; $display("FAIL stall_after_count got=%0d exp=%0d", fetch_count, c0 + 32'd1); end
  endtask

  task automatic test_return_bios();
    drive(1'b1, 1'b1, 32'h4000_0008);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    n_tests++; if (inst !== bios_mem[2]) begin n_fail++; $display("FAIL return_inst got=%h exp=%h", inst, bios_mem[2]); end
    n_tests++; if (inst_pc !== 32'h4000_0008) begin n_fail++; $display("FAIL return_pc got=%h exp=40000008", inst_pc); end
  endtask

  task automatic test_fault();
    logic [31:0] c0;
    drive(1'b0, 1'b1, 32'h2000_0000);
    tick();
    c0 = fetch_count;
    for (int k = 0; k < 6; k++) begin
      drive(k[0], 1'b0, 32'h0);
      n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL fault_valid[%0d] got=%b exp=0", k, inst_valid); end
      n_tests++; if (fetch_fault !== 1'b1) begin n_fail++; $display("FAIL fault_flag[%0d] got=%b exp=1", k, fetch_fault); end
      n_tests++; if (inst !== NOP) begin n_fail++; $display("FAIL fault_inst[%0d] got=%h exp=%h", k, inst, NOP); end
      n_tests++; if (inst_pc !== 32'h2000_0000) begin n_fail++; $display("FAIL fault_pc[%0d] got=%h exp=20000000", k, inst_pc); end
      n_tests++; if (fetch_count !== c0) begin n_fail++; $display("FAIL fault_count[%0d] got=%0d exp=%0d", k, fetch_count, c0); end
      tick();
    end
    drive(1'b0, 1'b1, 32'h4000_0000);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    n_tests++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL fault_exit_valid got=%b exp=1", inst_valid); end
    n_tests++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL fault_exit_flag got=%b exp=0", fetch_fault); end
    n_tests++; if (inst !== 32'h1000_02b7) begin n_fail++; $display("FAIL fault_exit_inst got=%h exp=100002b7", inst); end
  endtask

  task automatic test_boundary();
    drive(1'b0, 1'b1, 32'h4FFF_FFFC);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    n_tests++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL edge_valid got=%b exp=1", inst_valid); end
    n_tests++; if (inst !== bios_mem[4095]) begin n_fail++; $display("FAIL edge_inst got=%h exp=%h", inst, bios_mem[4095]); end
    tick();
    n_tests++; if (fetch_fault !== 1'b1) begin n_fail++; $display("FAIL edge_cross_fault got=%b exp=1", fetch_fault); end
    n_tests++; if (inst_pc !== 32'h5000_0000) begin n_fail++; $display("FAIL edge_cross_pc got=%h exp=50000000", inst_pc); end
    drive(1'b0, 1'b1, 32'h1000_0002);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    n_tests++; if (fetch_fault !== 1'b1) begin n_fail++; $display("FAIL misalign_fault got=%b exp=1", fetch_fault); end
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL misalign_valid got=%b exp=0", inst_valid); end
    drive(1'b0, 1'b1, 32'h1FFF_FFF8);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    n_tests++; if (inst !== imem_mem[16382]) begin n_fail++; $display("FAIL imem_top_inst got=%h exp=%h", inst, imem_mem[16382]); end
    tick();
    tick();
    n_tests++; if (fetch_fault !== 1'b1) begin n_fail++; $display("FAIL imem_cross_fault got=%b exp=1", fetch_fault); end
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    logic [31:0] npc;
    logic [31:0] exp_inst;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    tgt = 32'h4000_0000 + ($urandom_range(0, 8191) * 4);
        2, 3:    tgt = 32'h1000_0000 + ($urandom_range(0, 32767) * 4);
        4:       tgt = 32'h4FFF_FFF4 + ($urandom_range(0, 2) * 4);
        default: tgt = $urandom;
      endcase
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, tgt);
      npc      = model_next_pc();
      exp_inst = (m_mode == 1) ? word_at(m_pc) : NOP;
      n_tests++; if (inst_valid !== (m_mode == 1)) begin n_fail++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, inst_valid, m_mode == 1); end
      n_tests++; if (fetch_fault !== (m_mode == 2)) begin n_fail++; $display("FAIL rnd_fault[%0d] got=%b exp=%b", i, fetch_fault, m_mode == 2); end
      n_tests++; if (inst_pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", i, inst_pc, m_pc); end
      n_tests++; if (inst !== exp_inst) begin n_fail++; $display("FAIL rnd_inst[%0d] got=%h exp=%h", i, inst, exp_inst); end
      n_tests++; if (fetch_count !== m_count) begin n_fail++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", i, fetch_count, m_count); end
      n_tests++; if (bios_addr !== 12'((npc / 4) % 4096)) begin n_fail++; $display("FAIL rnd_bios_addr[%0d] got=%h exp=%h", i, bios_addr, 12'((npc / 4) % 4096)); end
      n_tests++; if (imem_addr !== 14'((npc / 4) % 16384)) begin n_fail++; $display("FAIL rnd_imem_addr[%0d] got=%h exp=%h", i, imem_addr, 14'((npc / 4) % 16384)); end
      tick();
    end
  endtask

  task automatic test_reset_midrun();
    drive(1'b0, 1'b1, 32'h1000_0040);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    tick();
    tick();
    n_tests++; if (inst_pc !== 32'h1000_0048) begin n_fail++; $display("FAIL mid_prerun_pc got=%h exp=10000048", inst_pc); end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got=%b exp=0", inst_valid); end
    n_tests++; if (inst !== NOP) begin n_fail++; $display("FAIL mid_rst_inst got=%h exp=%h", inst, NOP); end
    n_tests++; if (inst_pc !== RESET_PC) begin n_fail++; $display("FAIL mid_rst_pc got=%h exp=%h", inst_pc, RESET_PC); end
    n_tests++; if (fetch_count !== 32'd0) begin n_fail++; $display("FAIL mid_rst_count got=%0d exp=0", fetch_count); end
    tick();
    rst_n = 1'b1;
    #1;
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL mid_boot_valid got=%b exp=0", inst_valid); end
    tick();
    n_tests++; if (inst_pc !== 32'h4000_0000) begin n_fail++; $display("FAIL mid_first_pc got=%h exp=40000000", inst_pc); end
    n_tests++; if (inst !== 32'h1000_02b7) begin n_fail++; $display("FAIL mid_first_inst got=%h exp=100002b7", inst); end
    tick();
    n_tests++; if (fetch_count !== 32'd1) begin n_fail++; $display("FAIL mid_count got=%0d exp=1", fetch_count); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) bios_mem[i] = $urandom;
    for (int i = 0; i < 16384; i++) imem_mem[i] = $urandom;
    bios_mem[0] = 32'h1000_02b7;
    bios_mem[1] = 32'h0002_8067;
    imem_mem[0] = 32'h00a0_0293;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_boot();
    test_jump_imem();
    test_stall();
    test_return_bios();
    test_fault();
    test_boundary();
    test_random();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
